// File: rtl/pipeline_control_pkg.sv
// Shared types and constants for the pipeline sequencer.
package pipeline_control_pkg;

    localparam int unsigned STALL_W_DEF = 16;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } pipe_state_t;

endpackage : pipeline_control_pkg

// File: rtl/pipeline_control_if.sv
// Control bundle between the pipeline sequencer (master) and the datapath/caches (slave).
interface pipeline_control_if #(
    parameter int unsigned STALL_W = 16
);
    logic               ihit;
    logic               dhit;
    logic               dREN_m;
    logic               dWEN_m;
    logic               load_use;
    logic               redirect_ex;
    logic               halt_ex;
    logic               halt_wb;

    logic               pc_en;
    logic               ifid_en;
    logic               idex_en;
    logic               exmem_en;
    logic               memwb_en;
    logic               ifid_flush;
    logic               idex_flush;
    logic               imemREN;
    logic               dmemREN;
    logic               dmemWEN;
    logic               halted;
    logic [STALL_W-1:0] stall_cnt;

    modport master (
        input  ihit, dhit, dREN_m, dWEN_m, load_use, redirect_ex, halt_ex, halt_wb,
        output pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush,
               imemREN, dmemREN, dmemWEN, halted, stall_cnt
    );

    modport slave (
        output ihit, dhit, dREN_m, dWEN_m, load_use, redirect_ex, halt_ex, halt_wb,
        input  pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush,
               imemREN, dmemREN, dmemWEN, halted, stall_cnt
    );

endinterface : pipeline_control_if

// File: rtl/pipeline_control_hit_latch.sv
// Remembers a one-cycle memory completion until the pipeline actually advances.
module pipeline_control_hit_latch (
    input  logic CLK,
    input  logic nRST,
    input  logic i_hit,
    input  logic i_advance,
    output logic o_seen
);

    logic r_seen;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_seen <= 1'b0;
        end else if (i_advance) begin
            r_seen <= 1'b0;
        end else if (i_hit) begin
            r_seen <= 1'b1;
        end
    end

    assign o_seen = r_seen;

endmodule : pipeline_control_hit_latch

// File: rtl/pipeline_control.sv
// Pipeline sequencer: folds fetch/data completion, hazards, redirect and halt into
// one advance decision and drives latch enables, flushes and masked memory requests.
module pipeline_control
    import pipeline_control_pkg::*;
#(
    parameter int unsigned STALL_W = STALL_W_DEF
) (
    input  logic               CLK,
    input  logic               nRST,
    pipeline_control_if.master bus
);

    pipe_state_t        r_state;
    pipe_state_t        w_state_next;
    logic               w_ihit_seen;
    logic               w_dhit_seen;
    logic               w_dreq;
    logic               w_fetch_ok;
    logic               w_mem_ok;
    logic               w_advance;
    logic [STALL_W-1:0] r_stall_cnt;

    // Advance decision: both memories satisfied (now or earlier) and not halted.
    assign w_dreq     = bus.dREN_m | bus.dWEN_m;
    assign w_fetch_ok = bus.ihit | w_ihit_seen | (r_state == DRAIN);
    assign w_mem_ok   = ~w_dreq | bus.dhit | w_dhit_seen;
    assign w_advance  = w_fetch_ok & w_mem_ok & (r_state != HALTED);

    pipeline_control_hit_latch u_ihit_latch (
        .CLK       (CLK),
        .nRST      (nRST),
        .i_hit     (bus.ihit),
        .i_advance (w_advance),
        .o_seen    (w_ihit_seen)
    );

    pipeline_control_hit_latch u_dhit_latch (
        .CLK       (CLK),
        .nRST      (nRST),
        .i_hit     (bus.dhit),
        .i_advance (w_advance),
        .o_seen    (w_dhit_seen)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // A halt reaching WB wins over a halt entering EX in the same cycle.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            RUN: begin
                if (w_advance && bus.halt_wb) begin
                    w_state_next = HALTED;
                end else if (w_advance && bus.halt_ex) begin
                    w_state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (w_advance && bus.halt_wb) begin
                    w_state_next = HALTED;
                end
            end
            HALTED:  w_state_next = HALTED;
            default: w_state_next = RUN;
        endcase
    end

    // In DRAIN everything younger than the halt is dead, so bubbles replace any redirect.
    always_comb begin
        bus.pc_en      = 1'b0;
        bus.ifid_en    = 1'b0;
        bus.idex_en    = 1'b0;
        bus.exmem_en   = 1'b0;
        bus.memwb_en   = 1'b0;
        bus.ifid_flush = 1'b0;
        bus.idex_flush = 1'b0;
        bus.imemREN    = (r_state == RUN) & ~w_ihit_seen;
        bus.dmemREN    = bus.dREN_m & ~w_dhit_seen & (r_state != HALTED);
        bus.dmemWEN    = bus.dWEN_m & ~w_dhit_seen & (r_state != HALTED);
        bus.halted     = (r_state == HALTED);

        if (w_advance) begin
            bus.pc_en    = 1'b1;
            bus.ifid_en  = 1'b1;
            bus.idex_en  = 1'b1;
            bus.exmem_en = 1'b1;
            bus.memwb_en = 1'b1;
            if (r_state == DRAIN) begin
                bus.pc_en      = 1'b0;
                bus.ifid_flush = 1'b1;
                bus.idex_flush = 1'b1;
            end else if (bus.redirect_ex) begin
                bus.ifid_flush = 1'b1;
                bus.idex_flush = 1'b1;
            end else if (bus.load_use) begin
                bus.pc_en      = 1'b0;
                bus.ifid_en    = 1'b0;
                bus.idex_flush = 1'b1;
            end
        end
    end

    // Saturating count of live cycles lost to stalls.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_stall_cnt <= '0;
        end else if ((r_state != HALTED) && !w_advance && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + STALL_W'(1);
        end
    end

    assign bus.stall_cnt = r_stall_cnt;

endmodule : pipeline_control

// File: doc/pipeline_control.md
Name: pipeline_control

Overview:
- Central sequencer for the 5-stage pipeline latches (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC.
- Merges instruction-fetch completion (ihit), data-memory completion (dhit), load-use hazard, EX-stage redirect and halt into one advance decision per cycle.
- Drives per-latch enable/flush signals and masks memory requests.
- Runs a RUN/DRAIN/HALTED state machine so the pipeline empties cleanly on halt.

Parameters:
STALL_W, 16, width of saturating stall-cycle counter

Ports:
CLK  in  1  clock
nRST  in  1  async active-low reset
ihit  in  1  instruction fetch complete this cycle
dhit  in  1  data access complete this cycle
dREN_m  in  1  MEM-stage instruction requests load
dWEN_m  in  1  MEM-stage instruction requests store
load_use  in  1  ID instr reads rt of EX-stage load (from hazard unit)
redirect_ex  in  1  EX-stage taken branch/jump/jr
halt_ex  in  1  halt opcode in EX stage
halt_wb  in  1  halt opcode in WB stage
pc_en  out  1  PC update enable
ifid_en, idex_en, exmem_en, memwb_en  out  1 each  latch enables
ifid_flush, idex_flush  out  1 each  load bubble (all-zero) into latch on enable
imemREN  out  1  instruction fetch request
dmemREN, dmemWEN  out  1 each  masked data requests to cache
halted  out  1  sticky halt indicator
stall_cnt  out  STALL_W  cycles spent in RUN/DRAIN without advancing

Behaviour:
- Reset is asynchronous on nRST low.
  - state=RUN; ihit_seen=0; dhit_seen=0; stall_cnt=0; halted=0.
  - All outputs derive combinationally from these registers. At reset: enables 0 unless advance, flushes 0, imemREN=1.
- dreq = dREN_m | dWEN_m.
- fetch_ok = ihit | ihit_seen | (state==DRAIN).
- mem_ok = ~dreq | dhit | dhit_seen.
- advance = fetch_ok & mem_ok & (state!=HALTED).
- Hit latching, applied when advance is 0:
  - ihit sets ihit_seen.
  - dhit sets dhit_seen.
  - Both flags clear on any advance cycle.
  - The seen flags only hold a completion until the partner completes, so a 1-cycle ihit is never lost while dhit is outstanding, and vice versa.
- Request masking:
  - dmemREN = dREN_m & ~dhit_seen & (state!=HALTED).
  - dmemWEN = dWEN_m & ~dhit_seen & (state!=HALTED).
  - A store is never issued twice.
  - imemREN = (state==RUN) & ~ihit_seen.
- Latch enables when advance=1:
  - exmem_en = memwb_en = 1.
  - Default: pc_en = ifid_en = idex_en = 1.
  - When advance=0, every enable is 0 and every flush is 0.
- Priority within an advance cycle, highest first:
  1. redirect_ex: ifid_flush=1 and idex_flush=1. pc_en=1 (PC takes the redirect target). load_use is ignored.
  2. load_use: pc_en=0, ifid_en=0, idex_en=1, idex_flush=1 (bubble).
  3. Normal: no flush.
- FSM:
  - RUN -> DRAIN on advance & halt_ex.
  - DRAIN: pc_en=0, ifid_flush=1, idex_flush=1 on every advance. No fetch is required.
  - DRAIN -> HALTED on advance & halt_wb. Also RUN -> HALTED on advance & halt_wb (defensive).
  - HALTED: all enables 0, imemREN=dmemREN=dmemWEN=0, halted=1. The state is held until reset.
  - redirect_ex in DRAIN is ignored. The halt is older than the redirect, so the redirect is architecturally dead.
- stall_cnt increments by 1 on each cycle with state!=HALTED and advance=0. It saturates at all-ones with no wrap.
- Simultaneous ihit & dhit with dreq: advance in that cycle. The seen flags are not set.
- Reset mid-stall: the seen flags are discarded and the pipeline restarts in RUN.

Decomposition:
- cpu_types_pkg gains pipe_state_t enum {RUN, DRAIN, HALTED} (2 bits).
- One natural sub-module: hit_latch, a set-on-hit / clear-on-advance flag. It is instantiated twice, for ihit and for dhit.

Test Plan:
- Reset, then ihit=1 with dreq=0 for 3 cycles: all four latch enables and pc_en are 1 each cycle, stall_cnt=0, imemREN=1.
- dREN_m=1 with ihit in cycle 0 and dhit in cycle 3:
  - ihit_seen is set in cycle 0 and imemREN=0 in cycles 1-2.
  - Advance occurs in cycle 3 only.
  - stall_cnt=3.
- dWEN_m=1 with dhit in cycle 1 and ihit in cycle 4:
  - dmemWEN drops to 0 in cycles 2-4.
  - Advance occurs in cycle 4.
  - Exactly one store is issued.
- load_use=1 and redirect_ex=1 together with ihit: ifid_flush=1, idex_flush=1, pc_en=1. Next cycle with load_use only: pc_en=0, ifid_en=0, idex_flush=1.
- halt_ex with ihit:
  - state becomes DRAIN and imemREN=0.
  - Subsequent advances need no ihit.
  - When halt_wb is asserted on an advance: halted=1, all enables 0 permanently.
  - A further ihit or dhit has no effect.
- Force 2^STALL_W+5 stall cycles (ihit=0): stall_cnt saturates at 16'hFFFF. Asserting nRST low mid-stall immediately clears stall_cnt and both seen flags.
